// File: rtl/gcd_arbiter.sv
// Round-robin front end that shares one GCD engine among N requesters.
// Optional watchdog: define GCD_ARB_TIMEOUT_EN to enable eng_abort / rsp_err.
module gcd_arbiter #(
  parameter int N       = 4,
  parameter int W       = 16,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 1024,
  parameter int CW      = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   i_req_valid,
  output logic [N-1:0]   o_req_ready,
  input  logic [N*W-1:0] i_req_a,
  input  logic [N*W-1:0] i_req_b,
  output logic           o_eng_start,
  output logic [W-1:0]   o_eng_a,
  output logic [W-1:0]   o_eng_b,
  output logic           o_eng_abort,
  input  logic           i_eng_done,
  input  logic [W-1:0]   i_eng_result,
  output logic           o_rsp_valid,
  input  logic           i_rsp_ready,
  output logic [IDW-1:0] o_rsp_id,
  output logic [W-1:0]   o_rsp_data,
  output logic           o_rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP} state_t;

  state_t         r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_rsp_id;
  logic [W-1:0]   r_eng_a;
  logic [W-1:0]   r_eng_b;
  logic [W-1:0]   r_rsp_data;
  logic           r_eng_start;
  logic           r_rsp_valid;

  logic           w_any;
  logic [IDW-1:0] w_grant;
  logic [IDW-1:0] w_ptr_next;
  logic [W-1:0]   w_sel_a;
  logic [W-1:0]   w_sel_b;
  logic           w_timeout;

  // Scan from ptr downward in priority: the lowest offset from ptr wins.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req_valid[(int'(r_ptr) + k) % N]) begin
        w_any   = 1'b1;
        w_grant = IDW'((int'(r_ptr) + k) % N);
      end
    end
  end

  assign w_sel_a    = i_req_a[int'(w_grant)*W +: W];
  assign w_sel_b    = i_req_b[int'(w_grant)*W +: W];
  assign w_ptr_next = (r_rsp_id == IDW'(N - 1)) ? '0 : r_rsp_id + 1'b1;

  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign o_req_ready[gi] = rst_n && (r_state == S_IDLE) && w_any && (w_grant == IDW'(gi));
  end

`ifdef GCD_ARB_TIMEOUT_EN
  logic [CW-1:0] r_cnt;
  logic          r_rsp_err;

  // A done pulse in the timeout cycle wins over the abort.
  assign w_timeout   = (r_state == S_BUSY) && !i_eng_done && (r_cnt == CW'(TIMEOUT - 1));
  assign o_eng_abort = w_timeout;
  assign o_rsp_err   = r_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)
        r_cnt <= '0;
      else if (r_state == S_BUSY)
        r_cnt <= r_cnt + 1'b1;
      if (r_state == S_BUSY && i_eng_done)
        r_rsp_err <= 1'b0;
      else if (w_timeout)
        r_rsp_err <= 1'b1;
    end
  end
`else
  assign w_timeout   = 1'b0 && (TIMEOUT > 0) && (CW > 0);
  assign o_eng_abort = 1'b0;
  assign o_rsp_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_eng_start <= 1'b0;
      r_eng_a     <= '0;
      r_eng_b     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_eng_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_eng_a     <= w_sel_a;
            r_eng_b     <= w_sel_b;
            r_rsp_id    <= w_grant;
            r_eng_start <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_BUSY;
        S_BUSY: begin
          if (i_eng_done) begin
            r_rsp_data  <= i_eng_result;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (w_timeout) begin
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= w_ptr_next;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_eng_start = r_eng_start;
  assign o_eng_a     = r_eng_a;
  assign o_eng_b     = r_eng_b;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter with a behavioural GCD engine; set
// GCD_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT=8).
module tb_gcd_arbiter;

  localparam int N = 4;
  localparam int W = 16;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           eng_start;
  logic [W-1:0]   eng_a;
  logic [W-1:0]   eng_b;
  logic           eng_abort;
  logic           eng_done;
  logic [W-1:0]   eng_result;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;

  int checks = 0;
  int errors = 0;
  int eng_lat = 2;
  bit eng_hang = 1'b0;

  gcd_arbiter #(.N(N), .W(W), .IDW(IDW), .TIMEOUT(8), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b),
    .o_eng_start(eng_start), .o_eng_a(eng_a), .o_eng_b(eng_b),
    .o_eng_abort(eng_abort), .i_eng_done(eng_done), .i_eng_result(eng_result),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_id(rsp_id), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = y;
      y = x % y;
      x = t;
    end
    return x;
  endfunction

  // Engine: latches operands on eng_start, pulses done eng_lat cycles later.
  initial begin : engine
    logic [W-1:0] ea, eb;
    int lat;
    bit ok;
    eng_done = 1'b0;
    eng_result = '0;
    forever begin
      @(negedge clk);
      if (rst_n && eng_start) begin
        ea = eng_a;
        eb = eng_b;
        lat = eng_lat;
        ok = !eng_hang;
        for (int i = 0; i < lat; i++) begin
          @(negedge clk);
          if (!rst_n) ok = 1'b0;
        end
        if (ok && rst_n) begin
          eng_done = 1'b1;
          eng_result = gcd(ea, eb);
          @(negedge clk);
          eng_done = 1'b0;
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_eng_start"}, 32'(eng_start), 0);
    chk({tag, "_eng_a"}, 32'(eng_a), 0);
    chk({tag, "_eng_b"}, 32'(eng_b), 0);
    chk({tag, "_eng_abort"}, 32'(eng_abort), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
  endtask

  task automatic wait_grant(output int idx);
    int n = 0;
    #1;
    chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
    while (req_ready == 0 && n < 100) begin
      @(negedge clk);
      n++;
      chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
    end
    chk("grant_in_time", 32'(n < 100), 1);
    idx = -1;
    for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_in_time", 32'(n < 200), 1);
    $display("rsp id=%0d data=%0d err=%0d after %0d cycles", rsp_id, rsp_data, rsp_err, n);
  endtask

  logic [W-1:0] a_tab [N] = '{16'd12, 16'd35, 16'd0, 16'd17};
  logic [W-1:0] b_tab [N] = '{16'd8, 16'd21, 16'd9, 16'd5};
  logic [W-1:0] r_tab [N] = '{16'd4, 16'd7, 16'd9, 16'd1};
  int rr_order [5] = '{0, 1, 2, 3, 0};

  initial begin : main
    int g, n;
    bit stale;
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single request: gcd(48,18)=6, engine done 5 cycles after start
    eng_lat = 5;
    set_req(0, 16'd48, 16'd18);
    req_valid = 4'b0001;
    wait_grant(g);
    chk("single_grant", 32'(g), 0);
    chk("single_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    chk("single_start", 32'(eng_start), 1);
    chk("single_eng_a", 32'(eng_a), 48);
    chk("single_eng_b", 32'(eng_b), 18);
    wait_rsp(n);
    chk("single_latency", 32'(n), 6);
    chk("single_rsp_id", 32'(rsp_id), 0);
    chk("single_rsp_data", 32'(rsp_data), 6);
    chk("single_rsp_err", 32'(rsp_err), 0);
    chk("single_abort", 32'(eng_abort), 0);

    // Round robin from ptr=0 with all requesters valid
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    eng_lat = 2;
    for (int i = 0; i < N; i++) set_req(i, a_tab[i], b_tab[i]);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      chk("rr_order", 32'(g), 32'(rr_order[k]));
      @(negedge clk);
      chk("rr_start", 32'(eng_start), 1);
      chk("rr_eng_a", 32'(eng_a), 32'(a_tab[rr_order[k]]));
      chk("rr_eng_b", 32'(eng_b), 32'(b_tab[rr_order[k]]));
      wait_rsp(n);
      chk("rr_rsp_id", 32'(rsp_id), 32'(rr_order[k]));
      chk("rr_rsp_data", 32'(rsp_data), 32'(r_tab[rr_order[k]]));
    end

    // Requester 2 drops out while 1 is being served; 3 must be next
    req_valid = 4'b1110;
    wait_grant(g);
    chk("drop_first", 32'(g), 1);
    @(negedge clk);
    req_valid = 4'b1010;
    wait_rsp(n);
    chk("drop_rsp1", 32'(rsp_data), 7);
    wait_grant(g);
    chk("drop_next", 32'(g), 3);
    @(negedge clk);
    wait_rsp(n);
    chk("drop_rsp3", 32'(rsp_data), 1);
    wait_grant(g);
    chk("drop_wrap", 32'(g), 1);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(n);
    chk("drop_rsp1b", 32'(rsp_data), 7);

    // Backpressure: gcd(100,75)=25 held for 10 cycles while requester 1 waits
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(0, 16'd100, 16'd75);
    req_valid = 4'b0001;
    wait_grant(g);
    chk("bp_grant", 32'(g), 0);
    @(negedge clk);
    set_req(1, 16'd81, 16'd27);
    req_valid = 4'b0011;
    wait_rsp(n);
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_data", 32'(rsp_data), 25);
      chk("bp_id", 32'(rsp_id), 0);
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_start", 32'(eng_start), 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    eng_lat = 20;
    @(negedge clk);
    chk("bp_release_valid", 32'(rsp_valid), 0);
    chk("bp_release_ready", 32'(req_ready), 32'h2);

    // Reset while requester 1 is in BUSY
    @(negedge clk);
    chk("mid_start", 32'(eng_start), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    chk_reset_outputs("mid_async");
    @(negedge clk);
    chk_reset_outputs("mid_held");
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (rsp_valid || eng_start) stale = 1'b1;
    end
    chk("mid_no_stale", 32'(stale), 0);
    eng_lat = 3;
    set_req(3, 16'd17, 16'd5);
    req_valid = 4'b1001;
    wait_grant(g);
    chk("mid_ptr_zero", 32'(g), 0);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(n);
    chk("mid_rsp_id", 32'(rsp_id), 0);
    chk("mid_rsp_data", 32'(rsp_data), 25);

`ifdef GCD_ARB_TIMEOUT_EN
    // Engine never completes: abort in the 8th BUSY cycle
    @(negedge clk);
    eng_hang = 1'b1;
    req_valid = 4'b0001;
    wait_grant(g);
    @(negedge clk);
    req_valid = '0;
    chk("to_start", 32'(eng_start), 1);
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      chk("to_no_abort", 32'(eng_abort), 0);
    end
    @(negedge clk);
    chk("to_abort", 32'(eng_abort), 1);
    @(negedge clk);
    chk("to_rsp_valid", 32'(rsp_valid), 1);
    chk("to_rsp_err", 32'(rsp_err), 1);
    chk("to_rsp_data", 32'(rsp_data), 0);
    chk("to_abort_once", 32'(eng_abort), 0);
    eng_hang = 1'b0;
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_arbiter.md
# gcd_arbiter

Round-robin controller that shares one GCD engine among N requesters. It accepts an operand pair from one requester at a time and launches the engine with a start pulse. It waits for the engine's done pulse, then returns the result tagged with the requester's index on a single valid/ready response channel. It sits between the client ports and the GCD datapath/FSM pair, and is the only block that drives the engine's start and operand inputs.

## Interface
- N, default 4: number of requesters (2..8).
- W, default 16: operand/result width.
- IDW, default 2: requester index width; must satisfy 2**IDW >= N.
- TIMEOUT, default 1024: watchdog limit in cycles. Used only with the macro.
- CW, default 11: watchdog counter width; must satisfy 2**CW > TIMEOUT.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  N  per-requester request valid.
- req_ready  output  N  one-hot accept; reset 0.
- req_a  input  N*W  operand A, requester i at bits [i*W +: W].
- req_b  input  N*W  operand B, same packing.
- eng_start  output  1  one-cycle launch pulse; reset 0.
- eng_a  output  W  operand A to engine, registered; reset 0.
- eng_b  output  W  operand B to engine, registered; reset 0.
- eng_abort  output  1  one-cycle abort pulse; reset 0; tied 0 without the macro.
- eng_done  input  1  one-cycle completion pulse from engine.
- eng_result  input  W  engine result, valid with eng_done.
- rsp_valid  output  1  response valid; reset 0.
- rsp_ready  input  1  response accept.
- rsp_id  output  IDW  index of the served requester; reset 0.
- rsp_data  output  W  GCD result; reset 0.
- rsp_err  output  1  timeout flag; reset 0; tied 0 without the macro.

## Operation
- States: IDLE, ISSUE, BUSY, RESP. Reset state is IDLE. Round-robin pointer `ptr` resets to 0.
- IDLE:
  - Grant `g` = first i with req_valid[i]=1, searching ptr, ptr+1, … mod N.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - On the edge: capture req_a/req_b slice g into eng_a/eng_b, capture g into rsp_id, go to ISSUE.
  - With no req_valid set, stay in IDLE.
- ISSUE: eng_start=1 for exactly this cycle, then go to BUSY. eng_done seen in ISSUE is ignored.
- BUSY:
  - On eng_done: capture eng_result into rsp_data, set rsp_err=0, go to RESP.
  - eng_a/eng_b hold stable from ISSUE until the next IDLE grant.
- RESP:
  - rsp_valid=1. rsp_id, rsp_data and rsp_err are held stable until rsp_ready=1.
  - On the rsp_valid&&rsp_ready edge: ptr <= (rsp_id+1) mod N, go to IDLE.
- req_ready is 0 in every state other than IDLE. Only one request is outstanding at a time.
- Operands pass through unmodified, including zero operands. GCD semantics belong to the engine.
- Requesters must hold req_valid and operands stable until accepted. Dropping req_valid before acceptance is allowed and simply removes that requester from arbitration.
- reset asserted in any state:
  - Immediate return to IDLE, ptr=0, all outputs at their reset values.
  - Any in-flight result is discarded. The engine shares this reset.

## Timing
- Accept edge T0. eng_start is high in cycle T0+1.
- For eng_done in cycle T0+1+k (k>=1), rsp_valid rises in cycle T0+2+k.
- With rsp_ready held at 1, the earliest next accept is in cycle T0+3+k. Peak throughput is one operation per k+3 cycles.
- Fairness: every continuously requesting port is served within N grants.

## Configuration
- Macro: GCD_ARB_TIMEOUT_EN.
- Defined:
  - CW-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When the counter reaches TIMEOUT without eng_done: eng_abort=1 for one cycle, rsp_data=0, rsp_err=1, go to RESP.
  - eng_done arriving in the same cycle as the timeout takes priority as a normal completion.
  - A late eng_done after the timeout is ignored.
- Not defined:
  - No counter logic. BUSY waits indefinitely.
  - eng_abort and rsp_err are constant 0.

## Test plan
- Single request: req_valid=0001, a=48, b=18; engine done after 5 cycles with result 6. Required: eng_start in T0+1, rsp_valid in T0+7, rsp_id=0, rsp_data=6, rsp_err=0.
- All four requesters valid continuously, ptr=0. Required: grant order 0,1,2,3,0; req_ready is always one-hot or zero.
- Backpressure: rsp_ready=0 for 10 cycles in RESP. Required: rsp_valid stays 1, rsp_data/rsp_id stable, req_ready=0 throughout; no new eng_start.
- Mid-operation reset: reset low during BUSY. Required: next cycle shows IDLE, all outputs 0, ptr=0; the earlier result is never presented.
- Requester 2 drops req_valid before its turn while 1 and 3 are valid, after serving 1. Required: the next grant is 3.
- With GCD_ARB_TIMEOUT_EN, TIMEOUT=8, and an engine that never completes. Required: eng_abort pulses in the 8th BUSY cycle, then rsp_valid=1, rsp_err=1, rsp_data=0.
